// File: rtl/four_way_mux_select_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: registered one-hot GRANT and matching SELECT,
// with a hold limit that forces rotation when another requester is waiting.
module four_way_mux_select_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_BITS = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] REQ,
    output logic [3:0] GRANT,
    output logic [1:0] SELECT,
    output logic       BUSY,
    output logic       PREEMPT
);

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_OWNED = 1'b1;
    localparam logic [CNT_BITS-1:0] HOLD_MAX = CNT_BITS'(MAX_HOLD - 1);

    logic                state_q, state_d;
    logic [3:0]          grant_q, grant_d;
    logic [1:0]          select_q, select_d;
    logic                busy_q, busy_d;
    logic                preempt_q, preempt_d;
    logic [1:0]          last_q, last_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic [3:0]          search_req;
    logic [1:0]          search_start;
    logic [2:0]          pick;

    // Returns {found, index} of the first set bit at start, start+1, ... modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        if (state_q == ST_OWNED) begin
            search_req   = REQ & ~grant_q;
            search_start = select_q + 2'd1;
        end else begin
            search_req   = REQ;
            search_start = last_q + 2'd1;
        end
        pick = rr_pick(search_req, search_start);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        select_d  = select_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        last_d    = last_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    grant_d  = 4'b0001 << pick[1:0];
                    select_d = pick[1:0];
                    last_d   = pick[1:0];
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!REQ[select_q]) begin
                    if (pick[2]) begin
                        grant_d  = 4'b0001 << pick[1:0];
                        select_d = pick[1:0];
                        last_d   = pick[1:0];
                        cnt_d    = '0;
                    end else begin
                        grant_d = 4'b0000;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q < HOLD_MAX) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end else if (pick[2]) begin
                    grant_d   = 4'b0001 << pick[1:0];
                    select_d  = pick[1:0];
                    last_d    = pick[1:0];
                    cnt_d     = '0;
                    preempt_d = 1'b1;
                end else begin
                    // Saturate so the first competing request preempts immediately.
                    cnt_d = HOLD_MAX;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            select_q  <= 2'b00;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign GRANT   = grant_q;
    assign SELECT  = select_q;
    assign BUSY    = busy_q;
    assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_four_way_mux_select_arbiter.sv
// Bench for four_way_mux_select_arbiter: three instances (MAX_HOLD 1, 4, 8) on shared inputs,
// checked against vector tables, hand sequences and a per-instance owner/hold-count model.
module tb_four_way_mux_select_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] REQ;

    logic [3:0] g1, g4, g8;
    logic [1:0] s1, s4, s8;
    logic       b1, b4, b8;
    logic       p1, p4, p8;

    always #5 CLK = ~CLK;

    four_way_mux_select_arbiter #(.MAX_HOLD(1), .CNT_BITS(8)) u_h1 (
        .CLK(CLK), .RESET(RESET), .REQ(REQ),
        .GRANT(g1), .SELECT(s1), .BUSY(b1), .PREEMPT(p1)
    );
    four_way_mux_select_arbiter #(.MAX_HOLD(4), .CNT_BITS(8)) u_h4 (
        .CLK(CLK), .RESET(RESET), .REQ(REQ),
        .GRANT(g4), .SELECT(s4), .BUSY(b4), .PREEMPT(p4)
    );
    four_way_mux_select_arbiter #(.MAX_HOLD(8), .CNT_BITS(8)) u_h8 (
        .CLK(CLK), .RESET(RESET), .REQ(REQ),
        .GRANT(g8), .SELECT(s8), .BUSY(b8), .PREEMPT(p8)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: owner index (-1 when idle), last owner, shown select, cycles held so far.
    int m_max[3] = '{1, 4, 8};
    int m_owner[3];
    int m_last[3];
    int m_sel[3];
    int m_held[3];
    int m_pre[3];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        int         reps;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       pre;
    } vec_t;

    function automatic int rr(input logic [3:0] req, input int start);
        for (int i = 0; i < 4; i++) begin
            if (req[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    task automatic take(input int k, input int n);
        m_owner[k] = n;
        m_last[k]  = n;
        m_sel[k]   = n;
        m_held[k]  = 1;
    endtask

    task automatic model_step(input int k, input logic [3:0] req, input logic rst);
        logic [3:0] others;
        int         n;
        m_pre[k] = 0;
        if (rst) begin
            m_owner[k] = -1;
            m_last[k]  = 3;
            m_sel[k]   = 0;
            m_held[k]  = 0;
        end else if (m_owner[k] < 0) begin
            n = rr(req, (m_last[k] + 1) % 4);
            if (n >= 0) take(k, n);
        end else begin
            others = req;
            others[m_owner[k]] = 1'b0;
            n = rr(others, (m_owner[k] + 1) % 4);
            if (!req[m_owner[k]]) begin
                if (n >= 0) take(k, n);
                else m_owner[k] = -1;
            end else if (m_held[k] < m_max[k]) begin
                m_held[k]++;
            end else if (n >= 0) begin
                take(k, n);
                m_pre[k] = 1;
            end
        end
    endtask

    function automatic logic [7:0] model_vec(input int k);
        logic [3:0] eg;
        logic [1:0] es;
        eg = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
        es = 2'(m_sel[k]);
        return {eg, es, (m_owner[k] >= 0), (m_pre[k] != 0)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got grant/sel/busy/pre=%b expected %b", name, act, exp);
    endtask

    // Drive inputs, clock one edge, step models, then compare all instances 1 time unit later.
    task automatic cycle(input logic [3:0] req, input logic rst);
        REQ   = req;
        RESET = rst;
        @(posedge CLK);
        for (int k = 0; k < 3; k++) model_step(k, req, rst);
        #1;
        check("model_h1", {g1, s1, b1, p1}, model_vec(0));
        check("model_h4", {g4, s4, b4, p4}, model_vec(1));
        check("model_h8", {g8, s8, b8, p8}, model_vec(2));
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0] r;
        int         len;

        REQ   = 4'b0000;
        RESET = 1'b1;
        #2;

        // MAX_HOLD=4 instance: hold-limit rotation, saturation, release and idle restart.
        vecs.push_back('{1'b1, 4'b0000, 1,  4'b0000, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b1001, 4,  4'b0001, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 4'b1001, 1,  4'b1000, 2'd3, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 4'b1001, 3,  4'b1000, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 4'b1001, 1,  4'b0001, 2'd0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 4'b0000, 1,  4'b0000, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b0010, 10, 4'b0010, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 4'b0011, 1,  4'b0001, 2'd0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 4'b0100, 1,  4'b0100, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 4'b0000, 3,  4'b0000, 2'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 4'b1001, 1,  4'b1000, 2'd3, 1'b1, 1'b0});
        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].reps; j++) begin
                cycle(vecs[i].req, vecs[i].rst);
                check($sformatf("vec%0d_%0d", i, j), {g4, s4, b4, p4},
                      {vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].pre});
            end
        end

        // Default hold: release handoff with no bubble, then reset mid-grant and re-grant.
        cycle(4'b0000, 1'b1);
        check("rst_state", {g8, s8, b8, p8}, 8'b0000_00_0_0);
        cycle(4'b0101, 1'b0);
        check("first_grant", {g8, s8, b8, p8}, 8'b0001_00_1_0);
        cycle(4'b0100, 1'b0);
        check("release_handoff", {g8, s8, b8, p8}, 8'b0100_10_1_0);
        cycle(4'b0100, 1'b1);
        check("rst_midgrant", {g8, s8, b8, p8}, 8'b0000_00_0_0);
        cycle(4'b0100, 1'b0);
        check("regrant_after_rst", {g8, s8, b8, p8}, 8'b0100_10_1_0);

        // MAX_HOLD=1 rotates every cycle under full load.
        cycle(4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b0);
            check($sformatf("rot1_%0d", i), {g1, s1, b1},
                  {4'b0001 << (i % 4), 2'(i % 4), 1'b1});
        end

        // Randomized bursts of held request patterns with occasional reset.
        for (int i = 0; i < 300; i++) begin
            r   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                cycle(r, ($urandom_range(0, 99) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
